// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state enums plus default parameter constants for alu_issue_ctrl.
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_DEPTH = 8;
  localparam int DEF_OP_W = 3;
  localparam int DEF_TIMEOUT = 15;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOT  = 3'b100,
    OP_LOAD = 3'b101
  } op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register file with one synchronous write port and three combinational read ports.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  input  logic [ADDR_W-1:0] i_rdbg,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_rdbg
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rd1  = r_mem[i_ra1];
  assign o_rd2  = r_mem[i_ra2];
  assign o_rdbg = r_mem[i_rdbg];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes register-file commands, issues ALU operations and writes back results with a timeout.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_DEPTH = DEF_REG_DEPTH,
  parameter int OP_W = DEF_OP_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int ADDR_W = $clog2(REG_DEPTH),
  localparam int CMD_W = OP_W + 3 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [OP_W-1:0]   alu_op_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_req_valid,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_res_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_e r_state, w_next;
  logic [OP_W-1:0] r_op;
  logic [DATA_W-1:0] r_a, r_b;
  logic [ADDR_W-1:0] r_addr3;
  logic [CNT_W-1:0] r_cnt;
  logic r_req, r_done, r_err;
  logic [OP_W-1:0] w_op;
  logic [ADDR_W-1:0] w_a1, w_a2, w_a3;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic w_accept, w_is_alu, w_is_load, w_wait_hit, w_timeout;
  assign w_op = cmd[CMD_W-1 -: OP_W];
  assign w_a1 = cmd[3*ADDR_W-1 -: ADDR_W];
  assign w_a2 = cmd[2*ADDR_W-1 -: ADDR_W];
  assign w_a3 = cmd[ADDR_W-1:0];
  assign w_accept = cmd_valid && cmd_ready;
  assign w_is_alu = w_op <= OP_W'(OP_NOT);
  assign w_is_load = w_op == OP_W'(OP_LOAD);
  assign w_wait_hit = r_state == WAIT && alu_res_valid;
  assign w_timeout = r_state == WAIT && !alu_res_valid && r_cnt == CNT_W'(TIMEOUT - 1);
  // LOAD writes only from IDLE and results only from WAIT, so the two sources never collide.
  alu_regfile #(.DATA_W(DATA_W), .DEPTH(REG_DEPTH), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk),
    .rst(rst),
    .i_we((w_accept && w_is_load) || w_wait_hit),
    .i_waddr(w_wait_hit ? r_addr3 : w_a3),
    .i_wdata(w_wait_hit ? alu_res : cmd_imm),
    .i_ra1(w_a1),
    .i_ra2(w_a2),
    .i_rdbg(dbg_addr),
    .o_rd1(w_rd1),
    .o_rd2(w_rd2),
    .o_rdbg(dbg_data)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE  ? ((w_accept && w_is_alu) ? ISSUE : IDLE)
           : r_state == ISSUE ? WAIT
           : (alu_res_valid || w_timeout) ? IDLE : WAIT;
  end
  always_comb begin
    cmd_ready = r_state == IDLE && !rst;
    busy = r_state != IDLE;
  end
  // Operands are captured at accept so they stay stable through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_addr3 <= '0;
      r_cnt <= '0;
      r_req <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_req <= w_accept && w_is_alu;
      r_done <= (w_accept && !w_is_alu) || w_wait_hit;
      r_err <= w_timeout;
      r_cnt <= (r_state == WAIT && !alu_res_valid && !w_timeout) ? r_cnt + 1'b1 : '0;
      if (w_accept && w_is_alu) begin
        r_op <= w_op;
        r_a <= w_rd1;
        r_b <= (w_op == OP_W'(OP_NOT)) ? '0 : w_rd2;
        r_addr3 <= w_a3;
      end
    end
  end
  assign alu_op_code = r_op;
  assign alu_a = r_a;
  assign alu_b = r_b;
  assign alu_req_valid = r_req;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed literal scenarios plus randomized traffic checked against a cycle-timed transaction model.
module tb_alu_issue_ctrl;
  localparam int TO = 15;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [11:0] cmd = '0;
  logic [31:0] cmd_imm = '0, alu_a, alu_b, alu_res = '0, dbg_data;
  logic [2:0] alu_op_code, dbg_addr = '0;
  logic alu_req_valid, alu_res_valid = 0, busy, done, err;
  int errors = 0, checks = 0, n;
  bit chk_on = 0;
  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_imm(cmd_imm), .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_req_valid(alu_req_valid), .alu_res(alu_res), .alu_res_valid(alu_res_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted ALU op at cycle t0 issues in t0+1 and may complete in t0+2 .. t0+1+TO.
  logic [31:0] m_rf [8] = '{default: '0};
  bit m_busy = 0;
  int m_t0 = 0, m_dst = 0, cyc = 0;
  logic e_req = 0, e_done = 0, e_err = 0;
  logic [2:0] e_op = '0;
  logic [31:0] e_a = '0, e_b = '0;
  always @(posedge clk) begin
    logic [2:0] op;
    op = cmd[11:9];
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_busy = 0; e_req = 0; e_done = 0; e_err = 0; e_op = '0; e_a = '0; e_b = '0;
    end else begin
      e_req = 0; e_done = 0; e_err = 0;
      if (m_busy) begin
        if (cyc >= m_t0 + 2 && alu_res_valid) begin
          m_rf[m_dst] = alu_res; e_done = 1; m_busy = 0;
        end else if (cyc == m_t0 + 1 + TO) begin
          e_err = 1; m_busy = 0;
        end
      end else if (cmd_valid) begin
        if (op <= 3'd4) begin
          m_busy = 1; m_t0 = cyc; m_dst = int'(cmd[2:0]); e_req = 1; e_op = op;
          e_a = m_rf[cmd[8:6]];
          e_b = (op == 3'd4) ? 32'd0 : m_rf[cmd[5:3]];
        end else begin
          if (op == 3'd5) m_rf[cmd[2:0]] = cmd_imm;
          e_done = 1;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) if (chk_on) begin
    check("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !rst));
    check("busy", 32'(busy), 32'(m_busy));
    check("alu_req_valid", 32'(alu_req_valid), 32'(e_req));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(e_err));
    check("alu_op_code", 32'(alu_op_code), 32'(e_op));
    check("alu_a", alu_a, e_a);
    check("alu_b", alu_b, e_b);
    check("dbg_data", dbg_data, m_rf[dbg_addr]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [2:0] a3, input logic [31:0] imm);
    cmd_valid = 1; cmd = {op, a1, a2, a3}; cmd_imm = imm;
    tick();
  endtask

  initial begin
    tick();
    chk_on = 1;
    tick();
    rst = 0;
    issue(3'b101, 0, 0, 1, 32'd5);
    issue(3'b101, 0, 0, 2, 32'd3);
    check("lit_load_done", 32'(done), 32'd1);
    issue(3'b000, 1, 2, 3, 0);
    cmd_valid = 0;
    check("lit_add_req", 32'(alu_req_valid), 32'd1);
    check("lit_add_a", alu_a, 32'd5);
    check("lit_add_b", alu_b, 32'd3);
    check("lit_add_op", 32'(alu_op_code), 32'd0);
    alu_res = 32'd8; alu_res_valid = 1;
    tick();
    check("lit_wait_req", 32'(alu_req_valid), 32'd0);
    check("lit_wait_done", 32'(done), 32'd0);
    tick();
    alu_res_valid = 0; dbg_addr = 3;
    #1;
    check("lit_add_done", 32'(done), 32'd1);
    check("lit_rf3", dbg_data, 32'd8);
    issue(3'b001, 2, 1, 2, 0);
    cmd_valid = 0;
    check("lit_sub_a", alu_a, 32'd3);
    check("lit_sub_b", alu_b, 32'd5);
    alu_res = 32'hFFFF_FFFE; alu_res_valid = 1;
    tick();
    tick();
    alu_res_valid = 0; dbg_addr = 2;
    #1;
    check("lit_rf2_sub", dbg_data, 32'hFFFF_FFFE);
    issue(3'b100, 1, 5, 4, 0);
    check("lit_not_b", alu_b, 32'd0);
    check("lit_not_op", 32'(alu_op_code), 32'd4);
    check("lit_not_ready", 32'(cmd_ready), 32'd0);
    alu_res = 32'hFFFF_FFFA; alu_res_valid = 1;
    tick();
    check("lit_not_no_reaccept", 32'(alu_req_valid), 32'd0);
    tick();
    cmd_valid = 0; alu_res_valid = 0;
    issue(3'b000, 1, 2, 5, 0);
    cmd_valid = 0; n = 0;
    while (!err && n < 40) begin tick(); n++; end
    check("lit_timeout_cycles", n, 32'd16);
    dbg_addr = 5;
    #1;
    check("lit_timeout_nowrite", dbg_data, 32'd0);
    issue(3'b111, 0, 0, 3, 32'hDEAD);
    cmd_valid = 0;
    check("lit_nop_done", 32'(done), 32'd1);
    check("lit_nop_req", 32'(alu_req_valid), 32'd0);
    alu_res = 32'h1234; alu_res_valid = 1; dbg_addr = 3;
    tick();
    alu_res_valid = 0;
    check("lit_stray_nowrite", dbg_data, 32'd8);
    issue(3'b000, 1, 2, 3, 0);
    cmd_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0; alu_res = 32'h77; alu_res_valid = 1;
    tick();
    alu_res_valid = 0;
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_done", 32'(done), 32'd0);
    check("lit_rst_rf3", dbg_data, 32'd0);
    for (int c = 0; c < 3000; c++) begin
      bit fast;
      if (c % 200 == 0) fast = $urandom_range(1) == 1;
      rst = $urandom_range(99) == 0;
      cmd_valid = $urandom_range(1) == 1;
      cmd = 12'($urandom);
      cmd_imm = $urandom;
      alu_res = $urandom;
      alu_res_valid = fast ? ($urandom_range(1) == 1) : ($urandom_range(24) == 0);
      dbg_addr = 3'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
